puf_key_sequencer: RTL and testbench

- Upstream controller and downstream consumer of the ring-oscillator PUF core.
- Issues a series of challenges to the PUF and repeats each challenge REPEATS times.
- Majority-votes the 8-bit responses for each challenge and assembles a NUM_CHAL-byte key.
- Presents the key to the system through a valid/ready handshake.
- Each PUF measurement is launched by a parity change on CHALLENGE; completion is signalled by DONE returning high.

---
 rtl/puf_key_sequencer.sv | 167 ++++++++++++++++
 tb/tb_puf_key_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_key_sequencer.sv
// Drives a ring-oscillator PUF through repeated challenges, majority-votes the
// responses bit by bit and hands the assembled key to a consumer.
module puf_key_sequencer #(
    parameter int REPEATS  = 5,
    parameter int NUM_CHAL = 4,
    parameter int TIMEOUT  = 2097151
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [5:0]            seed,
    output logic [7:0]            challenge,
    input  logic [7:0]            response,
    input  logic                  done,
    output logic [8*NUM_CHAL-1:0] key,
    output logic                  key_valid,
    input  logic                  key_ready,
    output logic                  busy,
    output logic                  error,
    output logic [2:0]            dbg_state
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [3:0]    HALF     = 4'(REPEATS / 2);
    localparam logic [3:0]    REP_LAST = 4'(REPEATS - 1);
    localparam logic [4:0]    CHL_LAST = 5'(NUM_CHAL - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_SETTLE    = 3'd4,
        S_ACCUM     = 3'd5,
        S_PRESENT   = 3'd6
    } state_t;

    state_t        state;
    logic [5:0]    seed_q;
    logic [4:0]    chal_idx;
    logic [3:0]    rep;
    logic [3:0]    ones [7:1];
    logic [TW-1:0] tcnt;
    logic          settle_cnt;

    logic [5:0]    chal_low;
    logic [3:0]    ones_next [7:1];
    logic [7:0]    vote_byte;
    logic          unused_resp0;

    assign dbg_state    = state;
    assign chal_low     = seed_q + {1'b0, chal_idx};
    // Bit 0 of the response carries no entropy and is never voted.
    assign unused_resp0 = response[0];

    always_comb begin
        vote_byte = 8'h00;
        for (int b = 1; b <= 7; b++) begin
            ones_next[b] = ones[b] + {3'b000, response[b]};
            vote_byte[b] = (ones_next[b] > HALF);
        end
    end

    // Key handshake: key_valid is raised once the last byte is voted and key
    // holds still; the transfer happens on the first rising edge where
    // key_valid and key_ready are both high, after which key_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            seed_q     <= 6'd0;
            chal_idx   <= 5'd0;
            rep        <= 4'd0;
            tcnt       <= '0;
            settle_cnt <= 1'b0;
            challenge  <= 8'h00;
            key        <= '0;
            key_valid  <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
            for (int b = 1; b <= 7; b++) ones[b] <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        seed_q   <= seed;
                        error    <= 1'b0;
                        chal_idx <= 5'd0;
                        rep      <= 4'd0;
                        busy     <= 1'b1;
                        state    <= S_LAUNCH;
                        for (int b = 1; b <= 7; b++) ones[b] <= 4'd0;
                    end
                end
                S_LAUNCH: begin
                    // Bit 7 forces the overall parity to flip, which is what
                    // tells the PUF a new measurement has been requested.
                    challenge <= {~(^challenge) ^ (^chal_low), 1'b0, chal_low};
                    tcnt      <= '0;
                    state     <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (!done) begin
                        tcnt  <= '0;
                        state <= S_WAIT_HIGH;
                    end else if (tcnt == T_LAST) begin
                        error     <= 1'b1;
                        key_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (done) begin
                        settle_cnt <= 1'b0;
                        state      <= S_SETTLE;
                    end else if (tcnt == T_LAST) begin
                        error     <= 1'b1;
                        key_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt) state <= S_ACCUM;
                    else            settle_cnt <= 1'b1;
                end
                S_ACCUM: begin
                    if (rep != REP_LAST) begin
                        rep   <= rep + 4'd1;
                        state <= S_LAUNCH;
                        for (int b = 1; b <= 7; b++) ones[b] <= ones_next[b];
                    end else begin
                        for (int i = 0; i < NUM_CHAL; i++) begin
                            if (chal_idx == 5'(i)) key[8*i +: 8] <= vote_byte;
                        end
                        for (int b = 1; b <= 7; b++) ones[b] <= 4'd0;
                        rep      <= 4'd0;
                        chal_idx <= chal_idx + 5'd1;
                        if (chal_idx != CHL_LAST) begin
                            state <= S_LAUNCH;
                        end else begin
                            key_valid <= 1'b1;
                            state     <= S_PRESENT;
                        end
                    end
                end
                S_PRESENT: begin
                    if (key_ready) begin
                        key_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_key_sequencer.sv
// Bench for puf_key_sequencer: a behavioural PUF drives random measurement
// timing and responses, and each key is compared with a vote-counting model.
module tb_puf_key_sequencer;

    localparam int REPEATS  = 3;
    localparam int NUM_CHAL = 2;
    localparam int TIMEOUT  = 40;
    localparam int W        = 8 * NUM_CHAL;
    localparam int NR       = REPEATS * NUM_CHAL;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd3;
    localparam logic [2:0] ST_PRESENT   = 3'd6;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [5:0]   seed;
    logic [7:0]   challenge;
    logic [7:0]   response;
    logic         done;
    logic [W-1:0] key;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         error;
    logic [2:0]   dbg_state;

    puf_key_sequencer #(
        .REPEATS (REPEATS),
        .NUM_CHAL(NUM_CHAL),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .seed     (seed),
        .challenge(challenge),
        .response (response),
        .done     (done),
        .key      (key),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .busy     (busy),
        .error    (error),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   resp_q[$];
    logic [7:0]   launch_q[$];
    logic [7:0]   cur_resp [NR];
    bit           ref_par;
    bit           puf_hang;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural PUF ----------------
    bit prev_par;
    int m_phase;
    int m_cnt;

    initial begin
        done     = 1'b1;
        response = 8'h00;
        prev_par = 1'b0;
        m_phase  = 0;
        m_cnt    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_par = 1'b0;
                m_phase  = 0;
                done     = 1'b1;
            end else begin
                case (m_phase)
                    0: if ((^challenge) != prev_par) begin
                        prev_par = ^challenge;
                        launch_q.push_back(challenge);
                        if (!puf_hang) begin
                            m_phase = 1;
                            m_cnt   = $urandom_range(0, 3);
                        end
                    end
                    1: if (m_cnt == 0) begin
                        done     = 1'b0;
                        response = 8'($urandom);
                        m_phase  = 2;
                        m_cnt    = $urandom_range(1, 6);
                    end else m_cnt--;
                    2: if (m_cnt == 0) begin
                        response = (resp_q.size() > 0) ? resp_q.pop_front() : 8'($urandom);
                        done     = 1'b1;
                        m_phase  = 0;
                    end else m_cnt--;
                    default: m_phase = 0;
                endcase
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic model_key();
        logic [W-1:0] k;
        logic [7:0]   byte_v;
        int           cnt;
        k = '0;
        for (int c = 0; c < NUM_CHAL; c++) begin
            byte_v = 8'h00;
            for (int b = 1; b < 8; b++) begin
                cnt = 0;
                for (int r = 0; r < REPEATS; r++) cnt += int'(cur_resp[c*REPEATS + r][b]);
                if (2 * cnt > REPEATS) byte_v[b] = 1'b1;
            end
            k[8*c +: 8] = byte_v;
        end
        exp_q.push_back(k);
        for (int n = 0; n < NR; n++) resp_q.push_back(cur_resp[n]);
    endtask

    task automatic check_launches(input logic [5:0] sd);
        logic [7:0] c;
        logic [5:0] el;
        bit         ep;
        check("launch_count", launch_q.size(), NR);
        for (int n = 0; n < NR && launch_q.size() > 0; n++) begin
            c  = launch_q.pop_front();
            el = 6'((int'(sd) + n / REPEATS) % 64);
            ep = ~ref_par;
            check("launch_low6", c[5:0], el);
            check("launch_bit6", c[6], 1'b0);
            check("launch_par", ^c, ep);
            ref_par = ep;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [5:0] sd);
        @(negedge clk);
        seed  = sd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_err_clr", error, 1'b0);
    endtask

    task automatic run_key(input logic [5:0] sd, input int hold, input bit use_lit, input logic [W-1:0] lit);
        logic [W-1:0] exp;
        bit           ok;
        model_key();
        do_start(sd);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (key_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("key_valid_seen", ok, 1'b1);
        exp = exp_q.pop_front();
        check("key", key, exp);
        if (use_lit) check("key_lit", key, lit);
        check("present_state", dbg_state, ST_PRESENT);
        check_launches(sd);
        check("resp_drained", resp_q.size(), 0);
        for (int i = 0; i < hold; i++) begin
            start = (i == hold / 2) && (hold >= 4);
            seed  = ~sd;
            @(negedge clk);
            check("hold_key", key, exp);
            check("hold_valid", key_valid, 1'b1);
        end
        start = 1'b0;
        if (hold > 0) check("hold_state", dbg_state, ST_PRESENT);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        check("acc_valid", key_valid, 1'b0);
        check("acc_busy", busy, 1'b0);
        check("acc_state", dbg_state, ST_IDLE);
        check("acc_key", key, exp);
        check("acc_no_launch", launch_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_chal"}, challenge, 8'h00);
        check({tag, "_key"}, key, '0);
        check({tag, "_valid"}, key_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_err"}, error, 1'b0);
        check({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    task automatic timeout_test(input logic [5:0] sd);
        int cnt;
        bit ok;
        puf_hang = 1'b1;
        do_start(sd);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dbg_state == ST_WAIT_LOW) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("to_wait_low", ok, 1'b1);
        cnt = 0;
        while (!error && cnt < TIMEOUT + 10) begin
            @(negedge clk);
            cnt++;
        end
        check("to_cycles", cnt, TIMEOUT);
        check("to_error", error, 1'b1);
        check("to_busy", busy, 1'b0);
        check("to_valid", key_valid, 1'b0);
        check("to_state", dbg_state, ST_IDLE);
        check("to_chal_hold", challenge[5:0], sd);
        check("to_launches", launch_q.size(), 1);
        if (launch_q.size() > 0) begin
            bit ep;
            logic [7:0] c;
            c  = launch_q.pop_front();
            ep = ~ref_par;
            check("to_launch_par", ^c, ep);
            ref_par = ep;
        end
        repeat (5) @(negedge clk);
        check("to_err_sticky", error, 1'b1);
        puf_hang = 1'b0;
    endtask

    task automatic reset_mid_op(input logic [5:0] sd);
        bit ok;
        for (int n = 0; n < NR; n++) resp_q.push_back(8'($urandom));
        do_start(sd);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (launch_q.size() == 2 && dbg_state == ST_WAIT_HIGH) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst_reach_wh2", ok, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        launch_q.delete();
        resp_q.delete();
        ref_par = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        seed      = 6'd0;
        key_ready = 1'b0;
        puf_hang  = 1'b0;
        ref_par   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < NR; n++) cur_resp[n] = 8'hA7;
        run_key(6'h05, 0, 1'b1, 16'hA6A6);

        cur_resp[0] = 8'hF0; cur_resp[1] = 8'h0F; cur_resp[2] = 8'hF2;
        for (int n = REPEATS; n < NR; n++) cur_resp[n] = 8'h20;
        run_key(6'($urandom), 2, 1'b1, 16'h20F2);

        for (int n = 0; n < NR; n++) cur_resp[n] = (n < REPEATS) ? 8'h10 : 8'h20;
        run_key(6'h3F, 1, 1'b1, 16'h2010);

        for (int t = 0; t < 6; t++) begin
            for (int n = 0; n < NR; n++) cur_resp[n] = 8'($urandom);
            run_key(6'($urandom), $urandom_range(0, 3), 1'b0, '0);
        end

        for (int n = 0; n < NR; n++) cur_resp[n] = 8'($urandom);
        run_key(6'($urandom), 100, 1'b0, '0);

        timeout_test(6'h2A);
        for (int n = 0; n < NR; n++) cur_resp[n] = 8'($urandom);
        run_key(6'h2A, 0, 1'b0, '0);

        reset_mid_op(6'h11);
        for (int n = 0; n < NR; n++) cur_resp[n] = 8'($urandom);
        run_key(6'h11, 1, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
